// File: rtl/prog_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_rom_loader
// Brief    : Program memory with a combinational CPU fetch port and a
//            ready/valid loader. The CPU is stalled (HOLD) for the whole load.
//            Optional trailing checksum word, enabled by the macro
//            PROG_ROM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_rom_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DATA,
  input  logic              LD_START,
  input  logic              LD_ABORT,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic              LD_ERR,
  output logic              HOLD
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

`ifdef PROG_ROM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              load_go;   // load request accepted in IDLE
  logic              word_wr;   // accepted payload word is written this edge

  // Fetch port: plain asynchronous read of the program memory.
  assign DATA = mem[ADDR];

  // Next-state logic: abort beats a word arriving on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (LD_START) state_nxt = LOAD;
      LOAD: begin
        if (LD_ABORT) begin
          state_nxt = IDLE;
        end else if (LD_VALID && (wptr == LAST_PTR)) begin
`ifdef PROG_ROM_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef PROG_ROM_CHECKSUM_EN
      CHK: begin
        if (LD_ABORT)      state_nxt = IDLE;
        else if (LD_VALID) state_nxt = DONE;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and strobe decode from the current state.
  always_comb begin
    LD_READY = 1'b0;
    HOLD     = 1'b0;
    LD_DONE  = 1'b0;
    load_go  = 1'b0;
    word_wr  = 1'b0;
    case (state)
      IDLE: load_go = LD_START;
      LOAD: begin
        LD_READY = 1'b1;
        HOLD     = 1'b1;
        word_wr  = LD_VALID & ~LD_ABORT;
      end
`ifdef PROG_ROM_CHECKSUM_EN
      CHK: begin
        LD_READY = 1'b1;
        HOLD     = 1'b1;
      end
`endif
      DONE: begin
        HOLD    = 1'b1;
        LD_DONE = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write pointer: cleared on load start, wraps naturally after the last word.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)          wptr <= '0;
    else if (load_go) wptr <= '0;
    else if (word_wr) wptr <= wptr + 1'b1;
  end

  // Memory array: deliberately outside the reset so CLR never disturbs code.
  always_ff @(posedge CLK) begin
    if (word_wr) mem[wptr] <= LD_DATA;
  end

`ifdef PROG_ROM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              err;

  // Running modulo-2**DATA_W sum of payload words and sticky mismatch flag.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sum <= '0;
      err <= 1'b0;
    end else if (load_go) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (word_wr) sum <= sum + LD_DATA;
      if ((state == CHK) && LD_VALID && !LD_ABORT && (LD_DATA != sum)) err <= 1'b1;
    end
  end

  assign LD_ERR = err;
`else
  assign LD_ERR = 1'b0;
`endif

endmodule
`default_nettype wire
